// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
//   Sits between the keypad scanner and the alarm's 4-bit keypad input.
//   Collects a DIGITS-long PIN and checks it against the stored PIN. Only
//   a validated entry releases the one-cycle arm (4'b0011) or disarm
//   (4'b1100) code to the alarm. MAX_FAIL consecutive failed validations
//   lock the keypad for LOCKOUT cycles. A partial entry left idle for
//   TIMEOUT cycles is silently discarded.
//
//   Optional feature macro: KEYPAD_PIN_CHANGE_EN
//     defined   -> CHANGE (4'hD) after a valid PIN starts a new-PIN /
//                  confirm sequence that can replace the stored PIN.
//     undefined -> CHANGE is ignored like an illegal code and the PIN is
//                  fixed at PIN_DEFAULT.
//
//   Handshake: key_valid is a one-cycle strobe qualifying key_code in the
//   same cycle. There is no ready. Every strobe is taken, including strobes
//   on back-to-back cycles, except strobes that arrive while locked is high.
//
//   Ports
//     clk          : clock, all state changes on the rising edge
//     reset        : synchronous, active-low reset
//     key_valid    : key strobe
//     key_code     : 0-9 digit, A arm, B disarm, C clear, D change, E/F illegal
//     keypad_out   : code to the alarm, 0 except during a one-cycle pulse
//     cmd_ok       : one-cycle pulse when a command is accepted
//     entry_error  : one-cycle pulse when an entry is rejected
//     locked       : high during lockout
//     digit_count  : digits currently buffered
//
//   Latency: a key is captured into an input register at edge N and acted
//   on at edge N+1. All outputs are registered at edge N+1, so each pulse
//   occupies the cycle between edges N+1 and N+2.

module keypad_entry_ctrl #(
  parameter int unsigned          DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] PIN_DEFAULT = 16'h1234,
  parameter int unsigned          TIMEOUT     = 200,
  parameter int unsigned          MAX_FAIL    = 3,
  parameter int unsigned          LOCKOUT     = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] keypad_out,
  output logic       cmd_ok,
  output logic       entry_error,
  output logic       locked,
  output logic [3:0] digit_count
);

  localparam int unsigned PW = 4 * DIGITS;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned LW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam int unsigned FW = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;

  localparam logic [3:0] KEY_ARM     = 4'hA;
  localparam logic [3:0] KEY_DISARM  = 4'hB;
  localparam logic [3:0] KEY_CLEAR   = 4'hC;
`ifdef KEYPAD_PIN_CHANGE_EN
  localparam logic [3:0] KEY_CHANGE  = 4'hD;
`endif
  localparam logic [3:0] CODE_ARM    = 4'b0011;
  localparam logic [3:0] CODE_DISARM = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_LOCKOUT = 3'd2
`ifdef KEYPAD_PIN_CHANGE_EN
    ,
    S_NEWPIN  = 3'd3,
    S_CONFIRM = 3'd4
`endif
  } state_t;

  // What the current edge decided; the output process turns it into pulses.
  typedef enum logic [2:0] {
    EV_NONE    = 3'd0,
    EV_ARM     = 3'd1,
    EV_DISARM  = 3'd2,
    EV_PIN_SET = 3'd3,
    EV_REJECT  = 3'd4
  } event_t;

  state_t        state_q, state_d, cur;
  event_t        evt;
  logic          kv_q;
  logic [3:0]    kc_q;
  logic [PW-1:0] entry_q, entry_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [PW-1:0] pin_cur;
  logic          fail_hit, go_idle, is_digit, full, match;
  logic [3:0]    keypad_out_d;
  logic          cmd_ok_d, entry_error_d, locked_d;

`ifdef KEYPAD_PIN_CHANGE_EN
  logic [PW-1:0] pin_q, pin_d, new_pin_q, new_pin_d;
  assign pin_cur = pin_q;
`else
  assign pin_cur = PIN_DEFAULT;
`endif

  assign is_digit    = (kc_q <= 4'd9);
  assign full        = (cnt_q == 4'(DIGITS));
  assign match       = (entry_q == pin_cur);
  assign digit_count = cnt_q;

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      kv_q        <= 1'b0;
      kc_q        <= 4'd0;
      entry_q     <= '0;
      cnt_q       <= 4'd0;
      tmo_q       <= '0;
      lock_q      <= '0;
      fail_q      <= '0;
      keypad_out  <= 4'd0;
      cmd_ok      <= 1'b0;
      entry_error <= 1'b0;
      locked      <= 1'b0;
`ifdef KEYPAD_PIN_CHANGE_EN
      pin_q       <= PIN_DEFAULT;
      new_pin_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      // Keys presented while the lockout flag is visible are dropped here,
      // so the first key seen after locked falls is the first one accepted.
      kv_q        <= key_valid & ~locked;
      kc_q        <= key_code;
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      lock_q      <= lock_d;
      fail_q      <= fail_d;
      keypad_out  <= keypad_out_d;
      cmd_ok      <= cmd_ok_d;
      entry_error <= entry_error_d;
      locked      <= locked_d;
`ifdef KEYPAD_PIN_CHANGE_EN
      pin_q       <= pin_d;
      new_pin_q   <= new_pin_d;
`endif
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    lock_d   = lock_q;
    fail_d   = fail_q;
    evt      = EV_NONE;
    fail_hit = 1'b0;
    go_idle  = 1'b0;
    cur      = state_q;
`ifdef KEYPAD_PIN_CHANGE_EN
    pin_d     = pin_q;
    new_pin_d = new_pin_q;
`endif

    // Inter-key timer. On expiry the buffer is dropped and the key of this
    // same cycle is handled as if the controller were already idle.
    if (state_q == S_ENTRY
`ifdef KEYPAD_PIN_CHANGE_EN
        || state_q == S_NEWPIN || state_q == S_CONFIRM
`endif
       ) begin
      if (tmo_q == TW'(TIMEOUT)) begin
        cur     = S_IDLE;
        state_d = S_IDLE;
        entry_d = '0;
        cnt_d   = 4'd0;
        tmo_d   = '0;
`ifdef KEYPAD_PIN_CHANGE_EN
        if (state_q != S_ENTRY) evt = EV_REJECT;
`endif
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (cur)
      S_IDLE: begin
        if (kv_q && is_digit) begin
          entry_d = PW'(kc_q);
          cnt_d   = 4'd1;
          tmo_d   = '0;
          state_d = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (kv_q) begin
          if (is_digit) begin
            if (!full) begin
              entry_d = (entry_q << 4) | PW'(kc_q);
              cnt_d   = cnt_q + 4'd1;
              tmo_d   = '0;
            end else begin
              evt      = EV_REJECT;
              fail_hit = 1'b1;
              go_idle  = 1'b1;
            end
          end else if (kc_q == KEY_ARM || kc_q == KEY_DISARM) begin
            if (full && match) begin
              evt    = (kc_q == KEY_ARM) ? EV_ARM : EV_DISARM;
              fail_d = '0;
            end else begin
              evt      = EV_REJECT;
              fail_hit = 1'b1;
            end
            go_idle = 1'b1;
          end else if (kc_q == KEY_CLEAR) begin
            go_idle = 1'b1;
`ifdef KEYPAD_PIN_CHANGE_EN
          end else if (kc_q == KEY_CHANGE) begin
            if (full && match) begin
              state_d = S_NEWPIN;
              entry_d = '0;
              cnt_d   = 4'd0;
              tmo_d   = '0;
              fail_d  = '0;
            end else begin
              evt      = EV_REJECT;
              fail_hit = 1'b1;
              go_idle  = 1'b1;
            end
`endif
          end
        end
      end

      S_LOCKOUT: begin
        if (lock_q == LW'(LOCKOUT - 1)) begin
          state_d = S_IDLE;
          lock_d  = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end

`ifdef KEYPAD_PIN_CHANGE_EN
      // NEWPIN collects the new PIN, CONFIRM collects it a second time.
      // Problems here reject the change but never count as failures.
      S_NEWPIN, S_CONFIRM: begin
        if (kv_q) begin
          if (is_digit) begin
            if (!full) begin
              entry_d = (entry_q << 4) | PW'(kc_q);
              cnt_d   = cnt_q + 4'd1;
              tmo_d   = '0;
            end else begin
              evt     = EV_REJECT;
              go_idle = 1'b1;
            end
          end else if (kc_q == KEY_CHANGE) begin
            if (full && state_q == S_NEWPIN) begin
              new_pin_d = entry_q;
              state_d   = S_CONFIRM;
              entry_d   = '0;
              cnt_d     = 4'd0;
              tmo_d     = '0;
            end else if (full && entry_q == new_pin_q) begin
              pin_d   = entry_q;
              evt     = EV_PIN_SET;
              go_idle = 1'b1;
            end else begin
              evt     = EV_REJECT;
              go_idle = 1'b1;
            end
          end else if (kc_q == KEY_CLEAR) begin
            go_idle = 1'b1;
          end else if (kc_q == KEY_ARM || kc_q == KEY_DISARM) begin
            evt     = EV_REJECT;
            go_idle = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go_idle) begin
      state_d = S_IDLE;
      entry_d = '0;
      cnt_d   = 4'd0;
      tmo_d   = '0;
    end

    // The failure that reaches MAX_FAIL starts the lockout on the same edge
    // that registers its entry_error pulse.
    if (fail_hit) begin
      if (fail_q >= FW'(MAX_FAIL - 1)) begin
        state_d = S_LOCKOUT;
        lock_d  = '0;
        fail_d  = '0;
      end else begin
        fail_d = fail_q + 1'b1;
      end
    end
  end

  // Output decode, registered in the state register process.
  always_comb begin
    keypad_out_d  = 4'd0;
    cmd_ok_d      = 1'b0;
    entry_error_d = 1'b0;
    case (evt)
      EV_ARM: begin
        keypad_out_d = CODE_ARM;
        cmd_ok_d     = 1'b1;
      end
      EV_DISARM: begin
        keypad_out_d = CODE_DISARM;
        cmd_ok_d     = 1'b1;
      end
      EV_PIN_SET: cmd_ok_d      = 1'b1;
      EV_REJECT:  entry_error_d = 1'b1;
      default:    ;
    endcase
    locked_d = (state_d == S_LOCKOUT);
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Testbench for keypad_entry_ctrl (default build, fixed PIN 1234).
// The reference model works on a queue of entered digits and absolute
// edge numbers for the last accepted key and the remaining lockout time.

module tb_keypad_entry_ctrl;

  localparam int DIGITS   = 4;
  localparam int TIMEOUT  = 200;
  localparam int MAX_FAIL = 3;
  localparam int LOCKOUT  = 1000;
  localparam int PIN      = 32'h1234;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] keypad_out;
  logic       cmd_ok;
  logic       entry_error;
  logic       locked;
  logic [3:0] digit_count;

  keypad_entry_ctrl #(
    .DIGITS      (DIGITS),
    .PIN_DEFAULT (16'h1234),
    .TIMEOUT     (TIMEOUT),
    .MAX_FAIL    (MAX_FAIL),
    .LOCKOUT     (LOCKOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .keypad_out  (keypad_out),
    .cmd_ok      (cmd_ok),
    .entry_error (entry_error),
    .locked      (locked),
    .digit_count (digit_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Packed expectation: {keypad_out[3:0], cmd_ok, entry_error, locked, digit_count[3:0]}
  logic [10:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          gap_max = 0;

  // ---------------- reference model ----------------
  int          m_digs[$];
  int          m_now;
  int          m_last_acc;
  int          m_fails;
  int          m_lock_left;
  bit          pend_v;
  logic [3:0]  pend_c;

  task automatic model_init();
    m_digs.delete();
    m_now       = 0;
    m_last_acc  = 0;
    m_fails     = 0;
    m_lock_left = 0;
    pend_v      = 1'b0;
    pend_c      = 4'd0;
    exp_q.delete();
    exp_q.push_back(11'd0);
  endtask

  // One processing edge of the controller; returns the outputs after it.
  function automatic logic [10:0] model_edge(input bit v, input logic [3:0] c);
    logic [3:0] kp;
    bit         ok;
    bit         err;
    bit         fail;
    int         val;
    kp   = 4'd0;
    ok   = 1'b0;
    err  = 1'b0;
    fail = 1'b0;
    m_now++;
    if (m_lock_left > 0) begin
      m_lock_left--;
    end else begin
      if (m_digs.size() > 0 && (m_now - m_last_acc) > TIMEOUT) m_digs.delete();
      if (v) begin
        if (c <= 4'd9) begin
          if (m_digs.size() < DIGITS) begin
            m_digs.push_back(int'(c));
            m_last_acc = m_now;
          end else begin
            err  = 1'b1;
            fail = 1'b1;
            m_digs.delete();
          end
        end else if ((c == 4'hA || c == 4'hB) && m_digs.size() > 0) begin
          val = 0;
          foreach (m_digs[i]) val = val * 16 + m_digs[i];
          if (m_digs.size() == DIGITS && val == PIN) begin
            kp      = (c == 4'hA) ? 4'b0011 : 4'b1100;
            ok      = 1'b1;
            m_fails = 0;
          end else begin
            err  = 1'b1;
            fail = 1'b1;
          end
          m_digs.delete();
        end else if (c == 4'hC) begin
          m_digs.delete();
        end
      end
      if (fail) begin
        m_fails++;
        if (m_fails >= MAX_FAIL) begin
          m_fails     = 0;
          m_lock_left = LOCKOUT;
        end
      end
    end
    return {kp, ok, err, (m_lock_left > 0), 4'(m_digs.size())};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [10:0] e);
    n_cmp++;
    assert (keypad_out === e[10:7]) else begin
      n_err++;
      $error("FAIL %s keypad_out: observed %h expected %h", tag, keypad_out, e[10:7]);
    end
    n_cmp++;
    assert (cmd_ok === e[6]) else begin
      n_err++;
      $error("FAIL %s cmd_ok: observed %b expected %b", tag, cmd_ok, e[6]);
    end
    n_cmp++;
    assert (entry_error === e[5]) else begin
      n_err++;
      $error("FAIL %s entry_error: observed %b expected %b", tag, entry_error, e[5]);
    end
    n_cmp++;
    assert (locked === e[4]) else begin
      n_err++;
      $error("FAIL %s locked: observed %b expected %b", tag, locked, e[4]);
    end
    n_cmp++;
    assert (digit_count === e[3:0]) else begin
      n_err++;
      $error("FAIL %s digit_count: observed %0d expected %0d", tag, digit_count, e[3:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: check the outputs of the previous edge, drive a key,
  // and advance the model by the edge that processes the previous key.
  task automatic cycle(input bit v, input logic [3:0] c);
    logic [10:0] e;
    bit          pend_new;
    @(negedge clk);
    e = exp_q.pop_front();
    check("run", e);
    key_valid = v;
    key_code  = c;
    pend_new  = v && !e[4];
    exp_q.push_back(model_edge(pend_v, pend_c));
    pend_v = pend_new;
    pend_c = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'($urandom_range(0, 15)));
  endtask

  // Presses the n low nibbles of seq, most significant first.
  task automatic press_seq(input logic [31:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cycle(1'b1, seq[4*i +: 4]);
      idle(int'($urandom_range(0, gap_max)));
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("reset", 11'd0);
    end
    reset = 1'b1;
    model_init();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] seq;
    int          nd;
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    model_init();

    do_reset(10);

    // Arm then disarm, back-to-back keys.
    gap_max = 0;
    press_seq(32'h1234A, 5);
    idle(3);
    press_seq(32'h1234B, 5);
    idle(3);

    // Lockout, keys ignored while locked, arm afterwards.
    gap_max = 1;
    repeat (3) press_seq(32'h1235A, 5);
    press_seq(32'h1234A, 5);
    idle(LOCKOUT);
    press_seq(32'h1234A, 5);
    idle(4);

    // Lockout exit boundary: first key lands just before / just after.
    gap_max = 0;
    for (int off = -1; off <= 2; off++) begin
      do_reset(2);
      repeat (3) press_seq(32'h1235A, 5);
      idle(LOCKOUT + off);
      press_seq(32'h1234A, 5);
      idle(3);
    end

    // Timeout discards a partial entry.
    do_reset(2);
    press_seq(32'h12, 2);
    idle(TIMEOUT + 5);
    press_seq(32'h34A, 3);
    idle(3);

    // Timeout boundary around the inter-key gap.
    for (int g = TIMEOUT - 2; g <= TIMEOUT + 1; g++) begin
      do_reset(2);
      press_seq(32'h1, 1);
      idle(g);
      press_seq(32'h234A, 4);
      idle(3);
    end

    // Length errors, then a valid entry clears the failure count.
    do_reset(2);
    press_seq(32'h12345, 5);
    press_seq(32'h123A, 4);
    press_seq(32'h1234A, 5);
    press_seq(32'h1235B, 5);
    press_seq(32'h1235B, 5);
    press_seq(32'h1234B, 5);
    // CHANGE and illegal codes are ignored, CLEAR restarts the entry.
    press_seq(32'h1234DA, 6);
    press_seq(32'h12E34FA, 7);
    press_seq(32'h12C1234A, 8);
    idle(3);

    // Reset aborts an entry and a lockout.
    press_seq(32'h123, 3);
    do_reset(2);
    press_seq(32'h4A, 2);
    repeat (2) press_seq(32'hA99A, 4);
    idle(5);
    do_reset(2);
    press_seq(32'h1234A, 5);
    idle(3);

    // Randomized bursts.
    for (int b = 0; b < 150; b++) begin
      gap_max = int'($urandom_range(0, 2));
      case ($urandom_range(0, 4))
        0, 1: begin
          seq = {12'h000, 16'h1234, ($urandom_range(0, 1) != 0) ? 4'hA : 4'hB};
          press_seq(seq, 5);
        end
        2: begin
          nd  = int'($urandom_range(1, 6));
          seq = 32'd0;
          for (int i = 0; i < nd; i++) seq = (seq << 4) | 32'($urandom_range(0, 9));
          seq = (seq << 4) | 32'($urandom_range(10, 14));
          press_seq(seq, nd + 1);
        end
        3: begin
          for (int i = 0; i < 6; i++)
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        default: idle(int'($urandom_range(0, 230)));
      endcase
    end
    idle(5);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
